// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl -- forwarding selects and stall/bubble/flush control for a 5-stage pipeline.
// Build option: define FWD_HAZARD_FORWARD_EN for EX/MEM + WB forwarding; the default interlocks until writeback.
module fwd_hazard_ctrl #(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NB_REG-1:0] i_id_rs1,
  input  logic [NB_REG-1:0] i_id_rs2,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [NB_REG-1:0] i_id_rd,
  input  logic              i_id_reg_write,
  input  logic              i_id_mem_read,
  input  logic              i_id_valid,
  input  logic              i_branch_taken,
  output logic [1:0]        o_forward_rs1,
  output logic [1:0]        o_forward_rs2,
  output logic              o_stall,
  output logic              o_bubble,
  output logic              o_flush,
  output logic [NB_CNT-1:0] o_stall_cycles,
  output logic [NB_CNT-1:0] o_flush_count,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [NB_REG-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } shadow_t;

  localparam shadow_t SHADOW_NOP = '0;
  localparam int      N_STG      = 3;  // 0 = EX, 1 = MEM, 2 = WB
  localparam int      N_SRC      = 2;
  localparam int      N_CNT      = 2;  // 0 = stall cycles, 1 = flush count

  shadow_t           shadow_q [N_STG];
  shadow_t           ex_d;

  logic [NB_REG-1:0] src_idx   [N_SRC];
  logic [N_SRC-1:0]  src_used;
  logic [N_SRC-1:0]  src_live;
  logic [N_STG-1:0]  src_match [N_SRC];
  logic [N_SRC-1:0]  src_hazard;

  logic              hazard;
  logic              stall;
  logic              flush;
  logic              advance;
  state_t            state_q;
  state_t            state_d;

  logic [NB_CNT-1:0] cnt_q [N_CNT];
  logic [N_CNT-1:0]  cnt_inc;
  logic              unused_bits;

  assign src_idx[0] = i_id_rs1;
  assign src_idx[1] = i_id_rs2;
  assign src_used   = {i_id_rs2_used, i_id_rs1_used};

  genvar gi, gj;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      // x0 and unused sources never produce a dependency.
      assign src_live[gi] = i_id_valid & src_used[gi] & (src_idx[gi] != '0);
      for (gj = 0; gj < N_STG; gj++) begin : g_stg
        assign src_match[gi][gj] = src_live[gi] & shadow_q[gj].reg_write &
                                   (shadow_q[gj].rd == src_idx[gi]);
      end
`ifdef FWD_HAZARD_FORWARD_EN
      // Only a load still in EX has no value on the bypass network yet.
      assign src_hazard[gi] = src_match[gi][0] & shadow_q[0].mem_read;
`else
      assign src_hazard[gi] = |src_match[gi];
`endif
    end
  endgenerate

  assign hazard = |src_hazard;

  // Output decode: redirect outranks the hazard, and reset silences both.
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (i_reset) begin
      if (i_branch_taken) begin
        flush = 1'b1;
      end else if (hazard) begin
        stall = 1'b1;
      end
    end
  end

  assign o_stall  = stall;
  assign o_bubble = stall;
  assign o_flush  = flush;
  assign advance  = i_id_valid & ~stall & ~flush;

  always_comb begin
    state_d = ST_RUN;
    if (flush) begin
      state_d = ST_FLUSH;
    end else if (stall) begin
      state_d = ST_STALL;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_state = state_q;

  always_comb begin
    ex_d = SHADOW_NOP;
    if (advance) begin
      ex_d.rd        = i_id_rd;
      ex_d.reg_write = i_id_reg_write;
      ex_d.mem_read  = i_id_mem_read;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int s = 0; s < N_STG; s++) begin
        shadow_q[s] <= SHADOW_NOP;
      end
    end else begin
      shadow_q[0] <= ex_d;
      for (int s = 1; s < N_STG; s++) begin
        shadow_q[s] <= shadow_q[s-1];
      end
    end
  end

`ifdef FWD_HAZARD_FORWARD_EN
  logic [1:0] fwd_sel [N_SRC];
  logic [1:0] fwd_q   [N_SRC];

  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_fwd
      // Youngest producer wins: EX/MEM result before WB result.
      assign fwd_sel[gi] = src_match[gi][0] ? 2'b10 :
                           src_match[gi][1] ? 2'b01 : 2'b00;
    end
  endgenerate

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int s = 0; s < N_SRC; s++) begin
        fwd_q[s] <= 2'b00;
      end
    end else begin
      for (int s = 0; s < N_SRC; s++) begin
        fwd_q[s] <= advance ? fwd_sel[s] : 2'b00;
      end
    end
  end

  assign o_forward_rs1 = fwd_q[0];
  assign o_forward_rs2 = fwd_q[1];
  assign unused_bits   = ^{src_match[0][2], src_match[1][2], shadow_q[2].mem_read};
`else
  assign o_forward_rs1 = 2'b00;
  assign o_forward_rs2 = 2'b00;
  assign unused_bits   = shadow_q[2].mem_read;
`endif

  assign cnt_inc = {flush, stall};

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int s = 0; s < N_CNT; s++) begin
        cnt_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < N_CNT; s++) begin
        if (cnt_inc[s] && (cnt_q[s] != '1)) begin
          cnt_q[s] <= cnt_q[s] + NB_CNT'(1);
        end
      end
    end
  end

  assign o_stall_cycles = cnt_q[0];
  assign o_flush_count  = cnt_q[1];

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl -- directed bench with a pipeline-occupancy model checked every cycle.
// Build with or without FWD_HAZARD_FORWARD_EN; expectations follow the selected mode.
module tb_fwd_hazard_ctrl;
  localparam int NB_REG  = 5;
  localparam int NB_CNT  = 8;
  localparam int CNT_MAX = (1 << NB_CNT) - 1;
`ifdef FWD_HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NB_REG-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic              id_u1 = 1'b0, id_u2 = 1'b0, id_wr = 1'b0, id_ld = 1'b0, id_valid = 1'b0;
  logic              br = 1'b0;
  logic [1:0]        o_forward_rs1, o_forward_rs2, o_state;
  logic              o_stall, o_bubble, o_flush;
  logic [NB_CNT-1:0] o_stall_cycles, o_flush_count;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.NB_REG(NB_REG), .NB_CNT(NB_CNT)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_rs1_used(id_u1), .i_id_rs2_used(id_u2),
    .i_id_rd(id_rd), .i_id_reg_write(id_wr), .i_id_mem_read(id_ld), .i_id_valid(id_valid),
    .i_branch_taken(br),
    .o_forward_rs1(o_forward_rs1), .o_forward_rs2(o_forward_rs2),
    .o_stall(o_stall), .o_bubble(o_bubble), .o_flush(o_flush),
    .o_stall_cycles(o_stall_cycles), .o_flush_count(o_flush_count), .o_state(o_state)
  );

  // Model: what each downstream stage holds (0 = EX, 1 = MEM, 2 = WB).
  typedef struct { int rd; bit wr; bit ld; } rec_t;
  rec_t st [3];
  rec_t st_nxt [3];
  int   m_fwd [2];
  int   m_fwd_nxt [2];
  int   m_state, m_state_nxt, m_scnt, m_scnt_nxt, m_fcnt, m_fcnt_nxt;
  bit   m_stall, m_flush;
  int   n_checks = 0;
  int   n_errors = 0;

  int   src [2];
  bit   use_src [2];
  int   sel [2];
  bit   haz, adv;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: evaluates the rules on the settled inputs, checks, and prepares the next state.
  always @(negedge clk) begin
    #2;
    src[0] = int'(id_rs1); src[1] = int'(id_rs2);
    use_src[0] = id_u1;    use_src[1] = id_u2;
    haz = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel[s] = 0;
      if (id_valid && use_src[s] && src[s] != 0) begin
        if (FWD) begin
          if (st[0].wr && st[0].ld && st[0].rd == src[s]) haz = 1'b1;
          if (st[0].wr && st[0].rd == src[s]) sel[s] = 2;
          else if (st[1].wr && st[1].rd == src[s]) sel[s] = 1;
        end else begin
          for (int k = 0; k < 3; k++)
            if (st[k].wr && st[k].rd == src[s]) haz = 1'b1;
        end
      end
    end
    m_flush = rst_n && br;
    m_stall = rst_n && !br && haz;

    chk("flush",      int'(o_flush), int'(m_flush));
    chk("stall",      int'(o_stall), int'(m_stall));
    chk("bubble",     int'(o_bubble), int'(m_stall));
    chk("fwd_rs1",    int'(o_forward_rs1), m_fwd[0]);
    chk("fwd_rs2",    int'(o_forward_rs2), m_fwd[1]);
    chk("state",      int'(o_state), m_state);
    chk("stall_cnt",  int'(o_stall_cycles), m_scnt);
    chk("flush_cnt",  int'(o_flush_count), m_fcnt);

    adv = id_valid && !m_stall && !m_flush;
    st_nxt[2] = st[1];
    st_nxt[1] = st[0];
    st_nxt[0].rd = adv ? int'(id_rd) : 0;
    st_nxt[0].wr = adv ? id_wr : 1'b0;
    st_nxt[0].ld = adv ? id_ld : 1'b0;
    for (int s = 0; s < 2; s++) m_fwd_nxt[s] = (FWD && adv) ? sel[s] : 0;
    m_state_nxt = m_flush ? 2 : (m_stall ? 1 : 0);
    m_scnt_nxt  = (m_stall && m_scnt < CNT_MAX) ? m_scnt + 1 : m_scnt;
    m_fcnt_nxt  = (m_flush && m_fcnt < CNT_MAX) ? m_fcnt + 1 : m_fcnt;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        st[k].rd <= 0; st[k].wr <= 1'b0; st[k].ld <= 1'b0;
      end
      for (int s = 0; s < 2; s++) m_fwd[s] <= 0;
      m_state <= 0; m_scnt <= 0; m_fcnt <= 0;
    end else begin
      for (int k = 0; k < 3; k++) st[k] <= st_nxt[k];
      for (int s = 0; s < 2; s++) m_fwd[s] <= m_fwd_nxt[s];
      m_state <= m_state_nxt; m_scnt <= m_scnt_nxt; m_fcnt <= m_fcnt_nxt;
    end
  end

  // One cycle: drive at the falling edge, return after the compare process has run.
  task automatic cyc(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                     input int rd, input bit wr, input bit ld, input bit b);
    logic [31:0] t1, t2, t3;
    @(negedge clk);
    t1 = r1; t2 = r2; t3 = rd;
    id_valid = v; id_rs1 = t1[NB_REG-1:0]; id_u1 = u1; id_rs2 = t2[NB_REG-1:0]; id_u2 = u2;
    id_rd = t3[NB_REG-1:0]; id_wr = wr; id_ld = ld; br = b;
    #3;
  endtask

  // Present an instruction in ID and hold it there for as long as it is stalled.
  task automatic issue(input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit wr, input bit ld, output int stalls);
    stalls = 0;
    for (int n = 0; n < 8; n++) begin
      cyc(1'b1, r1, u1, r2, u2, rd, wr, ld, 1'b0);
      if (!m_stall) begin
        $display("issue rd=x%0d rs1=x%0d rs2=x%0d wr=%0d ld=%0d stalls=%0d", rd, r1, r2, wr, ld, stalls);
        return;
      end
      stalls++;
    end
    n_checks++;
    n_errors++;
    $display("FAIL stall_bound: got >=8 stall cycles, expected <=3 (t=%0t)", $time);
  endtask

  task automatic nop();
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int s;
    // Reset held with a redirect pending: nothing may assert.
    cyc(1'b1, 1, 1'b1, 0, 1'b0, 3, 1'b1, 1'b0, 1'b1);
    chk("rst_flush", int'(o_flush), 0);
    chk("rst_state", int'(o_state), 0);
    chk("rst_fcnt",  int'(o_flush_count), 0);
    br = 1'b0; id_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1; #3;

    // ALU producer then consumer.
    issue(1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b0, s);
    issue(5, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0, s);
    chk("A_stalls", s, FWD ? 0 : 3);
    nop();
    chk("A_fwd_rs1", int'(o_forward_rs1), FWD ? 2 : 0);

    // Load-use.
    issue(1, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, s);
    issue(5, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0, s);
    chk("B_stalls", s, FWD ? 1 : 3);
    nop();
    chk("B_fwd_rs1",   int'(o_forward_rs1), FWD ? 1 : 0);
    chk("B_stall_cnt", int'(o_stall_cycles), FWD ? 1 : 6);

    // x0 writer then x0 reader.
    issue(0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, s);
    issue(0, 1'b1, 0, 1'b1, 7, 1'b1, 1'b0, s);
    chk("C_stalls", s, 0);
    nop();
    chk("C_fwd_rs1", int'(o_forward_rs1), 0);
    chk("C_fwd_rs2", int'(o_forward_rs2), 0);

    // Load-use coinciding with a redirect.
    issue(0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b1, s);
    cyc(1'b1, 5, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0, 1'b1);
    chk("D_flush",  int'(o_flush), 1);
    chk("D_stall",  int'(o_stall), 0);
    chk("D_bubble", int'(o_bubble), 0);
    nop();
    chk("D_state", int'(o_state), 2);
    chk("D_fcnt",  int'(o_flush_count), 1);
    chk("D_fwd",   int'(o_forward_rs1), 0);

    // EX beats MEM on rs2; then a MEM-only producer on both sources.
    issue(0, 1'b0, 0, 1'b0, 11, 1'b1, 1'b0, s);
    issue(0, 1'b0, 0, 1'b0, 11, 1'b1, 1'b0, s);
    issue(0, 1'b0, 11, 1'b1, 12, 1'b1, 1'b0, s);
    chk("E_stalls", s, FWD ? 0 : 3);
    nop();
    chk("E_fwd_rs2", int'(o_forward_rs2), FWD ? 2 : 0);
    issue(0, 1'b0, 0, 1'b0, 13, 1'b1, 1'b0, s);
    issue(0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, s);
    issue(13, 1'b1, 13, 1'b1, 14, 1'b1, 1'b0, s);
    chk("E2_stalls", s, FWD ? 0 : 2);
    nop();
    chk("E2_fwd_rs1", int'(o_forward_rs1), FWD ? 1 : 0);
    chk("E2_fwd_rs2", int'(o_forward_rs2), FWD ? 1 : 0);

    // Invalid ID and unused sources are ignored.
    issue(0, 1'b0, 0, 1'b0, 15, 1'b1, 1'b1, s);
    cyc(1'b0, 15, 1'b1, 15, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("F_invalid_stall", int'(o_stall), 0);
    issue(0, 1'b0, 0, 1'b0, 16, 1'b1, 1'b1, s);
    cyc(1'b1, 16, 1'b0, 16, 1'b0, 17, 1'b1, 1'b0, 1'b0);
    chk("F_unused_stall", int'(o_stall), 0);
    nop();
    chk("F_unused_fwd", int'(o_forward_rs1), 0);

    // Reset asserted in the middle of a stall.
    issue(0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b1, s);
    cyc(1'b1, 5, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0, 1'b0);
    chk("G_stall_before", int'(o_stall), 1);
    rst_n = 1'b0;
    #1;
    chk("G_stall",  int'(o_stall), 0);
    chk("G_bubble", int'(o_bubble), 0);
    chk("G_flush",  int'(o_flush), 0);
    chk("G_scnt",   int'(o_stall_cycles), 0);
    chk("G_fcnt",   int'(o_flush_count), 0);
    chk("G_state",  int'(o_state), 0);
    chk("G_fwd",    int'(o_forward_rs1), 0);
    @(negedge clk); rst_n = 1'b1; #3;
    chk("G_no_residual", int'(o_stall), 0);
    nop();

    // Flush counter saturation.
    for (int n = 0; n < 260; n++) cyc(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    nop();
    chk("H_fcnt_sat", int'(o_flush_count), 255);
    chk("H_model_sat", m_fcnt, 255);
    chk("H_state", int'(o_state), 2);

    // Mixed traffic over a small register window, checked by the model.
    for (int n = 0; n < 300; n++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) != 0,
          $urandom_range(0, 7), $urandom_range(0, 1) != 0, $urandom_range(0, 7),
          $urandom_range(0, 1) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    nop();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
